// File: rtl/id_ctrl_pkg.sv
// rtl/id_ctrl_pkg.sv - opcode/ALU encodings and decoded control struct for the ID control stage
package id_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_RSV8  = 4'h8;
    localparam logic [3:0] OP_ADDI  = 4'h9;
    localparam logic [3:0] OP_LD    = 4'hA;
    localparam logic [3:0] OP_ST    = 4'hB;
    localparam logic [3:0] OP_BEZ   = 4'hC;
    localparam logic [3:0] OP_ILL_D = 4'hD;
    localparam logic [3:0] OP_ILL_E = 4'hE;
    localparam logic [3:0] OP_ILL_F = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_NONE = 3'b111;

    typedef struct packed {
        logic [2:0] alu_cmd;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       use_imm;
        logic       illegal;
        logic       reads_rs1;
        logic       reads_rs2;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'({ALU_NONE, 8'b0});

endpackage

// File: rtl/id_ctrl_if.sv
// rtl/id_ctrl_if.sv - upstream/downstream handshake bundle of the ID control stage
interface id_ctrl_if #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_alu_cmd;
    logic               out_reg_wr;
    logic               out_mem_rd;
    logic               out_mem_wr;
    logic               out_branch;
    logic               out_use_imm;
    logic               out_illegal;
    logic [REG_AW-1:0]  out_rd;
    logic [REG_AW-1:0]  out_rs1;
    logic [REG_AW-1:0]  out_rs2;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alu_cmd, out_reg_wr, out_mem_rd, out_mem_wr,
               out_branch, out_use_imm, out_illegal, out_rd, out_rs1, out_rs2
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alu_cmd, out_reg_wr, out_mem_rd, out_mem_wr,
               out_branch, out_use_imm, out_illegal, out_rd, out_rs1, out_rs2
    );
endinterface

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational opcode decode into control struct and register fields
module id_decode
    import id_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 3
) (
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl,
    output logic [REG_AW-1:0]  rd,
    output logic [REG_AW-1:0]  rs1,
    output logic [REG_AW-1:0]  rs2
);
    localparam int LOW_W = INSTR_W - OPC_W - 3 * REG_AW;

    logic [OPC_W-1:0] opc;

    assign opc = instr[INSTR_W-1 -: OPC_W];
    assign rd  = instr[INSTR_W-OPC_W-1 -: REG_AW];
    assign rs1 = instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign rs2 = instr[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];

    generate
        if (LOW_W > 0) begin : g_low
            logic unused_low;
            assign unused_low = ^instr[LOW_W-1:0];
        end
    endgenerate

    always_comb begin
        ctrl = CTRL_NOP;
        case (opc)
            OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND), OPC_W'(OP_OR),
            OPC_W'(OP_XOR), OPC_W'(OP_SLL), OPC_W'(OP_SRL): begin
                // register-register ops are encoded so that alu_cmd = opcode - 1
                ctrl.alu_cmd   = opc[2:0] - 3'd1;
                ctrl.reg_wr    = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            OPC_W'(OP_ADDI): begin
                ctrl.alu_cmd   = ALU_ADD;
                ctrl.reg_wr    = 1'b1;
                ctrl.use_imm   = 1'b1;
                ctrl.reads_rs1 = 1'b1;
            end
            OPC_W'(OP_LD): begin
                ctrl.alu_cmd   = ALU_ADD;
                ctrl.reg_wr    = 1'b1;
                ctrl.mem_rd    = 1'b1;
                ctrl.use_imm   = 1'b1;
                ctrl.reads_rs1 = 1'b1;
            end
            OPC_W'(OP_ST): begin
                ctrl.alu_cmd   = ALU_ADD;
                ctrl.mem_wr    = 1'b1;
                ctrl.use_imm   = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            OPC_W'(OP_BEZ): begin
                ctrl.branch    = 1'b1;
                ctrl.reads_rs1 = 1'b1;
            end
            OPC_W'(OP_ILL_D), OPC_W'(OP_ILL_E), OPC_W'(OP_ILL_F): begin
                ctrl.illegal   = 1'b1;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end
endmodule

// File: rtl/id_ctrl_stage.sv
// rtl/id_ctrl_stage.sv - registered ID/EX decode stage; ID_CTRL_HAZARD_EN enables the load-use interlock and stall_cnt
module id_ctrl_stage
    import id_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    id_ctrl_if.slave         bus
`ifdef ID_CTRL_HAZARD_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    ctrl_t             d_ctrl;
    ctrl_t             q_ctrl;
    logic [REG_AW-1:0] d_rd, d_rs1, d_rs2;
    logic [REG_AW-1:0] q_rd, q_rs1, q_rs2;
    logic              q_valid;
    logic              hazard;
    logic              accept;

    id_decode #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .REG_AW  (REG_AW)
    ) u_decode (
        .instr (bus.in_instr),
        .ctrl  (d_ctrl),
        .rd    (d_rd),
        .rs1   (d_rs1),
        .rs2   (d_rs2)
    );

`ifdef ID_CTRL_HAZARD_EN
    logic bubble;

    assign hazard = q_valid && q_ctrl.mem_rd && (q_rd != '0) && bus.in_valid &&
                    ((d_ctrl.reads_rs1 && (d_rs1 == q_rd)) ||
                     (d_ctrl.reads_rs2 && (d_rs2 == q_rd)));

    // a bubble only counts when the LD actually leaves; a flush cancels it
    assign bubble = hazard && bus.out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bubble && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_hazard;

    assign hazard        = 1'b0;
    assign unused_hazard = ^{d_ctrl.reads_rs1, d_ctrl.reads_rs2, {CNT_W{1'b0}}};
`endif

    // flush overrides backpressure so the incoming instruction is swallowed
    assign bus.in_ready = flush || ((!q_valid || bus.out_ready) && !hazard);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_ctrl  <= CTRL_NOP;
            q_rd    <= '0;
            q_rs1   <= '0;
            q_rs2   <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (accept) begin
            q_valid <= 1'b1;
            q_ctrl  <= d_ctrl;
            q_rd    <= d_rd;
            q_rs1   <= d_rs1;
            q_rs2   <= d_rs2;
        end else if (bus.out_ready) begin
            q_valid <= 1'b0;
        end
    end

    logic unused_q;
    assign unused_q = ^{q_ctrl.reads_rs1, q_ctrl.reads_rs2};

    assign bus.out_valid   = q_valid;
    assign bus.out_alu_cmd = q_ctrl.alu_cmd;
    assign bus.out_reg_wr  = q_ctrl.reg_wr;
    assign bus.out_mem_rd  = q_ctrl.mem_rd;
    assign bus.out_mem_wr  = q_ctrl.mem_wr;
    assign bus.out_branch  = q_ctrl.branch;
    assign bus.out_use_imm = q_ctrl.use_imm;
    assign bus.out_illegal = q_ctrl.illegal;
    assign bus.out_rd      = q_rd;
    assign bus.out_rs1     = q_rs1;
    assign bus.out_rs2     = q_rs2;
endmodule
